// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Define MDU_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops (9-12).
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMfhi  = 4'd7;
  localparam logic [3:0] OpMflo  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd9;
  localparam logic [3:0] OpMaddu = 4'd10;
  localparam logic [3:0] OpMsub  = 4'd11;
  localparam logic [3:0] OpMsubu = 4'd12;
`endif

  typedef enum logic {StIdle, StBusy} state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [CntW-1:0]   r_cnt;
  logic [31:0]       r_hi, r_lo, r_hi_n, r_lo_n;

  logic [63:0]        w_prod_s, w_prod_u, w_acc, w_res;
  logic signed [31:0] w_a_s, w_b_s, w_q_s, w_r_s;
  logic [31:0]        w_q_u, w_r_u;
  logic               w_valid;
  logic [CntW-1:0]    w_cycles;

  // Low 64 bits of a sign-extended product equal the signed product.
  assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign w_prod_u = {32'b0, A} * {32'b0, B};
  assign w_acc    = {r_hi, r_lo};
  assign w_a_s    = A;
  assign w_b_s    = B;
  assign w_q_s    = w_a_s / w_b_s;
  assign w_r_s    = w_a_s % w_b_s;
  assign w_q_u    = A / B;
  assign w_r_u    = A % B;

  // A zero divisor leaves the shadow equal to current HI/LO, so writeback is a no-op.
  always_comb begin
    w_res    = w_acc;
    w_valid  = 1'b0;
    w_cycles = CntW'(MULT_CYCLES);
    case (op)
      OpMult:  begin w_valid = 1'b1; w_res = w_prod_s; end
      OpMultu: begin w_valid = 1'b1; w_res = w_prod_u; end
      OpDiv: begin
        w_valid  = 1'b1;
        w_cycles = CntW'(DIV_CYCLES);
        if (B != '0) w_res = {w_r_s, w_q_s};
      end
      OpDivu: begin
        w_valid  = 1'b1;
        w_cycles = CntW'(DIV_CYCLES);
        if (B != '0) w_res = {w_r_u, w_q_u};
      end
`ifdef MDU_MADD_EN
      OpMadd:  begin w_valid = 1'b1; w_res = w_acc + w_prod_s; end
      OpMaddu: begin w_valid = 1'b1; w_res = w_acc + w_prod_u; end
      OpMsub:  begin w_valid = 1'b1; w_res = w_acc - w_prod_s; end
      OpMsubu: begin w_valid = 1'b1; w_res = w_acc - w_prod_u; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (start && w_valid) w_state_d = StBusy;
      StBusy:  if (r_cnt == CntW'(1)) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_hi_n  <= '0;
      r_lo_n  <= '0;
    end else begin
      r_state <= w_state_d;
      case (r_state)
        StIdle: begin
          if (start && w_valid) begin
            r_hi_n <= w_res[63:32];
            r_lo_n <= w_res[31:0];
            r_cnt  <= w_cycles;
          end
          if (op == OpMthi) r_hi <= A;
          if (op == OpMtlo) r_lo <= A;
        end
        StBusy: begin
          r_cnt <= r_cnt - CntW'(1);
          if (r_cnt == CntW'(1)) begin
            r_hi <= r_hi_n;
            r_lo <= r_lo_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state == StBusy);
  assign HI    = r_hi;
  assign LO    = r_lo;
  assign MDOut = (op == OpMfhi) ? r_hi : (op == OpMflo) ? r_lo : 32'd0;

endmodule
